// File: rtl/temp_bcd_display_conv_pkg.sv
// Shared constants for the temperature-to-BCD display path: the temperature
// field position in the raw sensor word, the FSM encoding and the double-dabble step.
package temp_pkg;

    localparam int TEMP_MSB = 15;
    localparam int TEMP_LSB = 7;
    localparam int TEMP_W   = 9;
    localparam int BCD_W    = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    // Double-dabble correction: bump every digit that would overflow on the next shift.
    function automatic logic [3*BCD_W-1:0] dabble_adjust(input logic [3*BCD_W-1:0] bcd);
        logic [3*BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*BCD_W +: BCD_W] >= 4'd5) begin
                adj[i*BCD_W +: BCD_W] = bcd[i*BCD_W +: BCD_W] + 4'd3;
            end else begin
                adj[i*BCD_W +: BCD_W] = bcd[i*BCD_W +: BCD_W];
            end
        end
        return adj;
    endfunction

endpackage

// File: rtl/temp_bcd_display_conv_settle.sv
// Settle filter: tracks the raw sensor word and counts how long its
// temperature field has stayed unchanged, since the reader has no valid strobe.
module temp_settle_filter
    import temp_pkg::*;
#(
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    output logic [15:0] stable_value,
    output logic        stable
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [15:0]      shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             same_s;

    // Restart the count on any temperature-field change, otherwise saturate upward.
    always_comb begin
        same_s   = (data_in[TEMP_MSB:TEMP_LSB] == shadow_q[TEMP_MSB:TEMP_LSB]);
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        if (!same_s) begin
            shadow_d = data_in;
            cnt_d    = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        stable       = (cnt_q == CNT_MAX) && same_s;
        stable_value = shadow_q;
    end

    // Filter state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= 16'h0000;
            cnt_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/temp_bcd_display_conv.sv
// Converts a settled 9-bit two's-complement half-degree reading into
// sign plus BCD digits for the seven-segment driver, one pulse per new value.
module temp_bcd_display_conv
    import temp_pkg::*;
#(
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      data_in,
    output logic             neg,
    output logic [BCD_W-1:0] bcd_hundreds,
    output logic [BCD_W-1:0] bcd_tens,
    output logic [BCD_W-1:0] bcd_ones,
    output logic [BCD_W-1:0] bcd_tenths,
    output logic             out_valid,
    output logic             busy
);

    logic [15:0]        stable_value_s;
    logic               stable_s;
    logic               trigger_s;
    logic               unused_low_s;
    logic [TEMP_W-1:0]  raw9_s, mag_s;
    logic [3*BCD_W-1:0] adj_s;

    logic [1:0]         state_q, state_d;
    logic [TEMP_W-1:0]  last_conv_q, last_conv_d;
    logic [7:0]         opnd_q, opnd_d;
    logic [3*BCD_W-1:0] bcd_q, bcd_d;
    logic [2:0]         iter_q, iter_d;
    logic               neg_r_q, neg_r_d, half_q, half_d, mag_zero_q, mag_zero_d;
    logic               neg_q, neg_d, out_valid_q, out_valid_d, busy_q, busy_d;
    logic [BCD_W-1:0]   hund_q, hund_d, tens_q, tens_d, ones_q, ones_d, tnth_q, tnth_d;

    temp_settle_filter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_settle (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .stable_value (stable_value_s),
        .stable       (stable_s)
    );

    // Operand decode, trigger detection and FSM next-state logic.
    always_comb begin
        unused_low_s = ^stable_value_s[TEMP_LSB-1:0];
        raw9_s       = stable_value_s[TEMP_MSB:TEMP_LSB];
        mag_s        = raw9_s[TEMP_W-1] ? (~raw9_s + 9'd1) : raw9_s;
        adj_s        = dabble_adjust(bcd_q);
        trigger_s    = (state_q == ST_IDLE) && stable_s && (raw9_s != last_conv_q);

        state_d     = state_q;
        last_conv_d = last_conv_q;
        opnd_d      = opnd_q;
        bcd_d       = bcd_q;
        iter_d      = iter_q;
        neg_r_d     = neg_r_q;
        half_d      = half_q;
        mag_zero_d  = mag_zero_q;
        neg_d       = neg_q;
        hund_d      = hund_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        tnth_d      = tnth_q;
        out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (trigger_s) begin
                    state_d     = ST_CONVERT;
                    last_conv_d = raw9_s;
                    opnd_d      = mag_s[8:1];
                    half_d      = mag_s[0];
                    neg_r_d     = raw9_s[TEMP_W-1];
                    mag_zero_d  = (mag_s == 9'd0);
                    bcd_d       = '0;
                    iter_d      = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONVERT: begin
                bcd_d  = {adj_s[3*BCD_W-2:0], opnd_q[7]};
                opnd_d = {opnd_q[6:0], 1'b0};
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CONVERT;
                end
            end
            ST_DONE: begin
                hund_d      = bcd_q[3*BCD_W-1:2*BCD_W];
                tens_d      = bcd_q[2*BCD_W-1:BCD_W];
                ones_d      = bcd_q[BCD_W-1:0];
                tnth_d      = half_q ? 4'd5 : 4'd0;
                neg_d       = neg_r_q && !mag_zero_q;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_CONVERT) || (state_d == ST_DONE);
    end

    // Datapath, FSM and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_conv_q <= '0;
            opnd_q      <= 8'd0;
            bcd_q       <= '0;
            iter_q      <= 3'd0;
            neg_r_q     <= 1'b0;
            half_q      <= 1'b0;
            mag_zero_q  <= 1'b0;
            neg_q       <= 1'b0;
            hund_q      <= 4'd0;
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            tnth_q      <= 4'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_conv_q <= last_conv_d;
            opnd_q      <= opnd_d;
            bcd_q       <= bcd_d;
            iter_q      <= iter_d;
            neg_r_q     <= neg_r_d;
            half_q      <= half_d;
            mag_zero_q  <= mag_zero_d;
            neg_q       <= neg_d;
            hund_q      <= hund_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            tnth_q      <= tnth_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign neg          = neg_q;
    assign bcd_hundreds = hund_q;
    assign bcd_tens     = tens_q;
    assign bcd_ones     = ones_q;
    assign bcd_tenths   = tnth_q;
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_temp_bcd_display_conv.sv
// Directed self-checking bench for temp_bcd_display_conv: settle latency,
// digit conversion, filter behaviour and reset/abort cases.
module tb_temp_bcd_display_conv;

    localparam int STABLE_CYCLES = 1024;
    // Edges counted from the drive point: first sampling edge plus STABLE_CYCLES+9.
    localparam int LAT = STABLE_CYCLES + 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic        neg, out_valid, busy;
    logic [3:0]  bcd_hundreds, bcd_tens, bcd_ones, bcd_tenths;

    int n_checks  = 0;
    int n_fail    = 0;
    int pulse_cnt = 0;
    int busy_cnt  = 0;

    temp_bcd_display_conv #(.STABLE_CYCLES(STABLE_CYCLES)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .neg          (neg),
        .bcd_hundreds (bcd_hundreds),
        .bcd_tens     (bcd_tens),
        .bcd_ones     (bcd_ones),
        .bcd_tenths   (bcd_tenths),
        .out_valid    (out_valid),
        .busy         (busy)
    );

    always #10 clk = ~clk;

    // Count pulses and busy cycles mid-cycle.
    always @(negedge clk) begin
        if (out_valid) pulse_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pulse(input string tag, input int budget, output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!out_valid && edges < budget);
        check({tag, "_pulse_seen"}, out_valid, 1);
    endtask

    task automatic check_out(input string tag, input logic n, input logic [3:0] h,
                             input logic [3:0] t, input logic [3:0] o, input logic [3:0] tn);
        check({tag, "_neg"}, neg, n);
        check({tag, "_hund"}, bcd_hundreds, h);
        check({tag, "_tens"}, bcd_tens, t);
        check({tag, "_ones"}, bcd_ones, o);
        check({tag, "_tenths"}, bcd_tenths, tn);
    endtask

    task automatic convert(input string tag, input logic [15:0] v, input logic n,
                           input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                           input logic [3:0] tn);
        int e, p0, b0;
        p0 = pulse_cnt;
        b0 = busy_cnt;
        data_in = v;
        wait_pulse(tag, LAT + 50, e);
        check({tag, "_latency"}, e, LAT);
        check_out(tag, n, h, t, o, tn);
        step(20);
        check({tag, "_one_pulse"}, pulse_cnt - p0, 1);
        check({tag, "_busy_cycles"}, busy_cnt - b0, 9);
    endtask

    initial begin
        int e, p0;
        logic [15:0] walk [6];
        walk = '{16'h8080, 16'h8180, 16'h8580, 16'h8480, 16'h8080, 16'h0080};

        reset   = 1'b1;
        data_in = 16'h0000;
        step(3);
        check_out("reset", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        check("reset_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;

        step(1200);
        check("zero_no_pulse", pulse_cnt, 0);

        convert("p25", 16'h1900, 1'b0, 4'd0, 4'd2, 4'd5, 4'd0);
        p0 = pulse_cnt;
        step(1500);
        check("saturate_no_retrigger", pulse_cnt - p0, 0);

        convert("p125", 16'h7D00, 1'b0, 4'd1, 4'd2, 4'd5, 4'd0);
        convert("m0p5", 16'hFF80, 1'b1, 4'd0, 4'd0, 4'd0, 4'd5);
        convert("m25", 16'hE700, 1'b1, 4'd0, 4'd2, 4'd5, 4'd0);
        convert("m128", 16'h8000, 1'b1, 4'd1, 4'd2, 4'd8, 4'd0);

        p0 = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            data_in = walk[i];
            step(200);
        end
        check("walk_no_intermediate", pulse_cnt - p0, 0);
        convert("walk_p0p5", walk[5], 1'b0, 4'd0, 4'd0, 4'd0, 4'd5);

        convert("p127p5", 16'h7F80, 1'b0, 4'd1, 4'd2, 4'd7, 4'd5);

        // Low bits churn every cycle; they must neither restart nor retrigger.
        p0 = pulse_cnt;
        e  = 0;
        do begin
            data_in = 16'h1900 | 16'($urandom_range(0, 127));
            @(posedge clk);
            #1;
            e++;
        end while (!out_valid && e < LAT + 50);
        check("lowbits_latency", e, LAT);
        check_out("lowbits", 1'b0, 4'd0, 4'd2, 4'd5, 4'd0);
        repeat (2000) begin
            data_in = 16'h1900 | 16'($urandom_range(0, 127));
            step(1);
        end
        check("lowbits_one_pulse", pulse_cnt - p0, 1);

        // New value arrives while the previous one is still converting.
        data_in = 16'hE700;
        step(1027);
        check("midconv_busy", busy, 1);
        data_in = 16'h7D00;
        wait_pulse("midconv_first", 50, e);
        check("midconv_first_edges", e, 7);
        check_out("midconv_first", 1'b1, 4'd0, 4'd2, 4'd5, 4'd0);
        wait_pulse("midconv_second", LAT + 50, e);
        check("midconv_second_edges", e, LAT - 7);
        check_out("midconv_second", 1'b0, 4'd1, 4'd2, 4'd5, 4'd0);

        // Reset mid-conversion aborts it and clears everything.
        step(5);
        data_in = 16'hFF80;
        step(1028);
        check("rstmid_busy", busy, 1);
        p0 = pulse_cnt;
        reset = 1'b1;
        step(1);
        check_out("rstmid", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        check("rstmid_valid", out_valid, 0);
        check("rstmid_busy_clr", busy, 0);
        reset = 1'b0;
        wait_pulse("rstmid_reconv", LAT + 50, e);
        check("rstmid_reconv_latency", e, LAT);
        check("rstmid_no_early_pulse", pulse_cnt - p0, 0);
        check_out("rstmid_reconv", 1'b1, 4'd0, 4'd0, 4'd0, 4'd5);

        step(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
